sc_ride_ctrl: RTL

- Sits directly downstream of the saucer layer.
- Consumes the saucer position, Q*bert-on-saucer flag, saucer state and move-done flag.
- Takes ownership of Q*bert's screen position while he rides the saucer, then walks him down onto the top cube.
- Its position output feeds the Q*bert display layer. Its lock output freezes the jump controller.

---
 rtl/sc_ride_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sc_ride_ctrl.sv
// sc_ride_ctrl: owns Q*bert's position while he rides the saucer, then walks him onto the top cube.
//
// Ports:
//   clk, reset (async, active-low)
//   e_pause_qb / e_resume_qb / e_start_qb : game pause, resume, restart (restart only from PAUSE)
//   e_XY0_qb     : top cube landing point {x[20:10], y[9:0]}
//   soucoupe_xy  : saucer centre; qb_on_sc: Q*bert in catch window
//   state_sc     : saucer state (0 INIT, 1 MOVE, 2 END); done_move_sc: saucer travel complete
//   qbert_xy_in  : position from the jump controller (passed through while idle)
//   qbert_xy_out : registered position to the display layer
//   qb_lock      : high while this block owns the position
//   ride_active  : high while riding; ride_done: one-cycle pulse when the landing hold ends
//
// Optional feature: define RIDE_BOB_EN to add a 1-pixel vertical bob while riding.
module sc_ride_ctrl #(
    parameter logic [9:0]  RIDE_YOFF = 10'd12,
    parameter logic [31:0] DROP_DIV  = 32'd100000,
    parameter logic [31:0] LAND_HOLD = 32'd1000000
`ifdef RIDE_BOB_EN
    ,
    parameter logic [4:0]  BOB_SHIFT = 5'd20
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_pause_qb,
    input  logic        e_resume_qb,
    input  logic        e_start_qb,
    input  logic [20:0] e_XY0_qb,
    input  logic [20:0] soucoupe_xy,
    input  logic        qb_on_sc,
    input  logic [1:0]  state_sc,
    input  logic        done_move_sc,
    input  logic [20:0] qbert_xy_in,
    output logic [20:0] qbert_xy_out,
    output logic        qb_lock,
    output logic        ride_active,
    output logic        ride_done
);
    localparam logic [1:0] R_IDLE = 2'd0, R_RIDE = 2'd1, R_DROP = 2'd2, R_LAND = 2'd3;
    localparam logic [1:0] G_RESUME = 2'd0, G_PAUSE = 2'd1, G_RESTART = 2'd2;
    logic [1:0]  ride_q, ride_d, game_q, game_d;
    logic [10:0] xr_q, xr_d;
    logic [9:0]  yr_q, yr_d;
    logic [31:0] step_q, step_d, hold_q, hold_d;
    logic [20:0] xy_q, xy_d;
    logic        lock_q, lock_d, active_q, active_d, done_q, done_d;
    logic        run;
    logic [9:0]  ride_y, show_y;
    logic [10:0] tx;
    logic [9:0]  ty;
    // The ride FSM only moves in RESUME, and not in the cycle a pause is requested.
    assign run    = (game_q == G_RESUME) && !e_pause_qb;
    assign ride_y = soucoupe_xy[9:0] - RIDE_YOFF;
    assign tx     = e_XY0_qb[20:10];
    assign ty     = e_XY0_qb[9:0];
`ifdef RIDE_BOB_EN
    logic [31:0] bob_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) bob_q <= '0;
        else if (run) bob_q <= bob_q + 32'd1;
    // The bob only affects what is drawn; the latched drop start uses ride_y.
    assign show_y = ride_y - {9'd0, bob_q[BOB_SHIFT]};
`else
    assign show_y = ride_y;
`endif
    always_comb
        game_d = (game_q == G_RESUME) ? (e_pause_qb ? G_PAUSE : G_RESUME)
               : (game_q == G_PAUSE)  ? (e_resume_qb ? G_RESUME : e_start_qb ? G_RESTART : G_PAUSE)
               : G_RESUME;
    always_comb begin
        ride_d   = ride_q;
        xr_d     = xr_q;
        yr_d     = yr_q;
        step_d   = step_q;
        hold_d   = hold_q;
        xy_d     = xy_q;
        lock_d   = lock_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (game_q == G_RESTART) begin
            ride_d   = R_IDLE;
            step_d   = '0;
            hold_d   = '0;
            lock_d   = 1'b0;
            active_d = 1'b0;
        end else if (run) begin
            lock_d   = ride_q != R_IDLE;
            active_d = ride_q == R_RIDE;
            case (ride_q)
                R_IDLE: begin
                    xy_d = qbert_xy_in;
                    if (qb_on_sc && state_sc == 2'd1) ride_d = R_RIDE;
                end
                R_RIDE: begin
                    xy_d = {soucoupe_xy[20:10], show_y};
                    if (done_move_sc && state_sc == 2'd2) begin
                        xr_d   = soucoupe_xy[20:10];
                        yr_d   = ride_y;
                        step_d = '0;
                        ride_d = R_DROP;
                    end else if (state_sc == 2'd0) begin
                        ride_d = R_IDLE;
                    end
                end
                R_DROP: begin
                    xy_d = {xr_q, yr_q};
                    if (step_q == DROP_DIV) begin
                        step_d = '0;
                        // Walk x first, then y, one pixel per step tick.
                        if (xr_q != tx) xr_d = (xr_q < tx) ? xr_q + 11'd1 : xr_q - 11'd1;
                        else if (yr_q != ty) yr_d = (yr_q < ty) ? yr_q + 10'd1 : yr_q - 10'd1;
                        else begin
                            hold_d = '0;
                            ride_d = R_LAND;
                        end
                    end else begin
                        step_d = step_q + 32'd1;
                    end
                end
                default: begin
                    xy_d = {xr_q, yr_q};
                    if (hold_q + 32'd1 >= LAND_HOLD) begin
                        hold_d = '0;
                        done_d = 1'b1;
                        ride_d = R_IDLE;
                    end else begin
                        hold_d = hold_q + 32'd1;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            game_q   <= G_RESUME;
            ride_q   <= R_IDLE;
            xr_q     <= '0;
            yr_q     <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            xy_q     <= '0;
            lock_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            game_q   <= game_d;
            ride_q   <= ride_d;
            xr_q     <= xr_d;
            yr_q     <= yr_d;
            step_q   <= step_d;
            hold_q   <= hold_d;
            xy_q     <= xy_d;
            lock_q   <= lock_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    assign qbert_xy_out = xy_q;
    assign qb_lock      = lock_q;
    assign ride_active  = active_q;
    assign ride_done    = done_q;
endmodule
